// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regfile
// Purpose  : 8-bit APB completer with a DEPTH x 8 register file and
//            WAIT_STATES programmable wait states. Optional macro
//            APB_SLAVE_PSLVERR_EN adds the pslverr error response.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic       pclk,
    input  logic       prst,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready
`ifdef APB_SLAVE_PSLVERR_EN
    ,
    output logic       pslverr
`endif
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_SLOTS  = 1 << c_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_write;
    logic [7:0] r_addr;
    logic [7:0] r_prdata;
    logic       r_pready;
    logic [7:0] r_regs [c_SLOTS];
`ifdef APB_SLAVE_PSLVERR_EN
    logic       r_pslverr;
`endif

    logic       w_setup;
    logic       w_access;
    logic [7:0] w_rd_addr;
    logic       w_rd_write;
    logic       w_rd_in_range;
    logic [7:0] w_rd_data;
    logic       w_wr_in_range;
    logic       w_go_ready;

    assign w_setup  = psel & ~penable;
    assign w_access = psel & penable;

    // With zero wait states READY is entered on the setup edge itself, so the
    // read path must look at the live bus rather than the not-yet-loaded latch.
    assign w_rd_addr     = (r_state == S_IDLE) ? paddr  : r_addr;
    assign w_rd_write    = (r_state == S_IDLE) ? pwrite : r_write;
    assign w_rd_in_range = ({1'b0, w_rd_addr} < 9'(DEPTH));
    assign w_rd_data     = w_rd_in_range ? r_regs[w_rd_addr[c_ADDR_W-1:0]] : 8'h00;
    assign w_wr_in_range = ({1'b0, r_addr} < 9'(DEPTH));

    assign w_go_ready = ((r_state == S_IDLE) && w_setup && (WAIT_STATES == 0)) ||
                        ((r_state == S_WAIT) && w_access && (r_cnt == 4'd1));

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_write  <= 1'b0;
            r_addr   <= 8'h00;
            r_prdata <= 8'h00;
            r_pready <= 1'b0;
`ifdef APB_SLAVE_PSLVERR_EN
            r_pslverr <= 1'b0;
`endif
            for (int i = 0; i < c_SLOTS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_write <= pwrite;
                        r_addr  <= paddr;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_READY;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_STATES);
                        end
                    end
                end
                S_WAIT: begin
                    if (!psel) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (penable) begin
                        if (r_cnt == 4'd1) begin
                            r_state <= S_READY;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                S_READY: begin
                    // Completion (psel & penable) or abort (psel low) both end here.
                    if (!psel || penable) begin
                        if (psel && r_write && w_wr_in_range) begin
                            r_regs[r_addr[c_ADDR_W-1:0]] <= pwdata;
                        end
                        r_state  <= S_IDLE;
                        r_prdata <= 8'h00;
                        r_pready <= 1'b0;
`ifdef APB_SLAVE_PSLVERR_EN
                        r_pslverr <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_go_ready) begin
                r_pready <= 1'b1;
                r_prdata <= w_rd_write ? 8'h00 : w_rd_data;
`ifdef APB_SLAVE_PSLVERR_EN
                r_pslverr <= ~w_rd_in_range;
`endif
            end
        end
    end

    assign prdata = r_prdata;
    assign pready = r_pready;
`ifdef APB_SLAVE_PSLVERR_EN
    assign pslverr = r_pslverr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regfile
// Purpose  : Directed self-checking bench for apb_slave_regfile, one instance
//            with two wait states and one with zero wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

    logic       pclk    = 1'b0;
    logic       prst    = 1'b1;
    logic       psel0   = 1'b0;
    logic       psel1   = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite  = 1'b0;
    logic [7:0] paddr   = 8'h00;
    logic [7:0] pwdata  = 8'h00;
    logic [7:0] prdata0, prdata1;
    logic       pready0, pready1;
`ifdef APB_SLAVE_PSLVERR_EN
    logic       pslverr0, pslverr1;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(2)) u_dut_ws2 (
        .pclk    (pclk),
        .prst    (prst),
        .psel    (psel0),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata0),
        .pready  (pready0)
`ifdef APB_SLAVE_PSLVERR_EN
        ,
        .pslverr (pslverr0)
`endif
    );

    apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(0)) u_dut_ws0 (
        .pclk    (pclk),
        .prst    (prst),
        .psel    (psel1),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata1),
        .pready  (pready1)
`ifdef APB_SLAVE_PSLVERR_EN
        ,
        .pslverr (pslverr1)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input bit d, input string tag, input logic rdy,
                              input logic [7:0] rd, input logic err);
        chk({tag, ".pready"}, {7'd0, (d ? pready1 : pready0)}, {7'd0, rdy});
        chk({tag, ".prdata"}, (d ? prdata1 : prdata0), rd);
`ifdef APB_SLAVE_PSLVERR_EN
        chk({tag, ".pslverr"}, {7'd0, (d ? pslverr1 : pslverr0)}, {7'd0, err});
`else
        if (err === 1'bx) $display("unexpected X on err flag for %s", tag);
`endif
    endtask

    // Full transfer; after the setup edge paddr/pwrite are scrambled and pwdata
    // carries its real value only in the final access cycle.
    task automatic xfer(input bit d, input bit wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd,
                        input logic exp_err, input string tag);
        int  ws;
        bit  last;
        ws = d ? 0 : 2;
        @(posedge pclk); #1;
        psel0 = !d; psel1 = d; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = ~wd;
        @(negedge pclk);
        check_outs(d, {tag, ".T0"}, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= ws + 1; k++) begin
            @(posedge pclk); #1;
            last    = (k == ws + 1);
            penable = 1'b1;
            pwrite  = !wr;
            paddr   = a ^ 8'h01;
            pwdata  = last ? wd : ~wd;
            @(negedge pclk);
            check_outs(d, $sformatf("%s.T%0d", tag, k), last,
                       (last && !wr) ? exp_rd : 8'h00, last ? exp_err : 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
            @(negedge pclk);
            check_outs(1'b0, "idle0", 1'b0, 8'h00, 1'b0);
            check_outs(1'b1, "idle1", 1'b0, 8'h00, 1'b0);
        end
    endtask

    initial begin
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check_outs(1'b0, "rst0", 1'b0, 8'h00, 1'b0);
        check_outs(1'b1, "rst1", 1'b0, 8'h00, 1'b0);
        @(posedge pclk); #1;
        prst = 1'b0;
        idle(1);

        // Basic write/read with two wait states
        xfer(1'b0, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, "wr3");
        xfer(1'b0, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, "rd3");
        idle(1);

        // Out-of-range read and write; 0x20 aliases addr 0 in the low bits
        xfer(1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, "rd_oor");
        xfer(1'b0, 1'b1, 8'h20, 8'hFF, 8'h00, 1'b1, "wr_oor");
        xfer(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "rd0_clean");
        xfer(1'b0, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, "rd3_keep");

        // Back-to-back writes and reads with no idle cycle
        xfer(1'b0, 1'b1, 8'h00, 8'h11, 8'h00, 1'b0, "b2b_wr0");
        xfer(1'b0, 1'b1, 8'h01, 8'h22, 8'h00, 1'b0, "b2b_wr1");
        xfer(1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0, "b2b_rd0");
        xfer(1'b0, 1'b0, 8'h01, 8'h00, 8'h22, 1'b0, "b2b_rd1");
        idle(1);

        // Abort: psel dropped in the first access cycle of a write to addr 5
        xfer(1'b0, 1'b1, 8'h05, 8'h66, 8'h00, 1'b0, "wr5");
        @(posedge pclk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h77;
        @(negedge pclk);
        check_outs(1'b0, "abort.T0", 1'b0, 8'h00, 1'b0);
        @(posedge pclk); #1;
        psel0 = 1'b0; penable = 1'b1;
        @(negedge pclk);
        check_outs(1'b0, "abort.T1", 1'b0, 8'h00, 1'b0);
        idle(4);
        xfer(1'b0, 1'b0, 8'h05, 8'h00, 8'h66, 1'b0, "rd5_keep");

        // Reset pulsed while a read of addr 2 sits in WAIT
        xfer(1'b0, 1'b1, 8'h02, 8'h3C, 8'h00, 1'b0, "wr2");
        @(posedge pclk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h02;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        prst = 1'b1;
        #1;
        check_outs(1'b0, "rst_mid", 1'b0, 8'h00, 1'b0);
        @(posedge pclk); #1;
        prst = 1'b0; psel0 = 1'b0; penable = 1'b0;
        idle(1);
        xfer(1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, "rd2_after_rst");
        xfer(1'b0, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, "rd3_after_rst");
        idle(1);

        // Zero wait states: two-cycle transfers
        xfer(1'b1, 1'b1, 8'h07, 8'h5A, 8'h00, 1'b0, "ws0_wr7");
        xfer(1'b1, 1'b0, 8'h07, 8'h00, 8'h5A, 1'b0, "ws0_rd7");
        xfer(1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, "ws0_rd_oor");
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer with a small byte-wide register file, programmable wait states and optional error response. It sits on the peripheral side of the 8-bit APB bus and answers the bus master's setup/access transfers. It is the register target for the master in simulation and for simple peripherals in silicon.

## Interface
- DEPTH, 16: number of 8-bit registers, at addresses 0..DEPTH-1 (1..256)
- WAIT_STATES, 2: access cycles with pready low before the ready cycle (0..15)
- pclk  in  1  bus clock; all logic on rising edge
- prst  in  1  reset, asynchronous, active-high
- psel  in  1  slave select
- penable  in  1  access-phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  8  register address
- pwdata  in  8  write data
- prdata  out  8  read data, registered
- pready  out  1  transfer-complete, registered
- pslverr  out  1  error response, registered (present only with APB_SLAVE_PSLVERR_EN)

## Operation
- Reset: prdata=0x00, pready=0, pslverr=0, FSM=IDLE, wait counter=0, all registers=0x00.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - psel=1, penable=0 sampled at an edge (setup phase): latch pwrite and paddr internally.
  - If WAIT_STATES=0: go to READY.
  - Else: go to WAIT with cnt=WAIT_STATES.
  - penable=1 without a prior setup is ignored; stay IDLE.
- WAIT:
  - If psel=1 and penable=1: at cnt==1 go to READY, else cnt-=1.
  - If psel=0: abort; go to IDLE with no write and no output change.
- Entering READY: pready<=1.
  - Read: prdata<=reg[latched paddr].
  - Out of range (paddr>=DEPTH): prdata<=0x00 and, with the macro, pslverr<=1.
- READY:
  - Edge with psel=1 and penable=1 is the completion edge.
  - Write: reg[latched paddr]<=pwdata, in range only; out-of-range writes are dropped.
  - Then go to IDLE with pready, pslverr and prdata all <=0.
  - psel=0 in READY: abort, no write, go to IDLE, outputs cleared.
- Address and direction come from the setup-phase latch. paddr, pwrite or pwdata changes during access do not retarget the transfer. pwdata is sampled only at the completion edge.
- Back-to-back: a setup phase in the cycle after completion is accepted from IDLE with no dead cycle.
- Reset asserted mid-transfer: immediate return to reset values, registers included.

## Timing
- Setup phase in cycle T0. Access cycles run T1..T(WAIT_STATES+1). pready=1 only in T(WAIT_STATES+1).
- Transfer latency is WAIT_STATES+2 cycles, including setup.
- prdata and pslverr are valid only while pready=1, and are 0 in every other cycle.
- A write is visible to a read whose setup phase is the cycle after write completion.
- pready is never high for two consecutive cycles.

## Configuration
- APB_SLAVE_PSLVERR_EN defined:
  - pslverr port exists.
  - pslverr is asserted together with pready for any out-of-range read or write.
- Undefined:
  - No pslverr port.
  - Out-of-range reads silently return 0x00 and out-of-range writes are silently dropped.

## Test plan
- Write 0xA5 to addr 0x03, then read 0x03 (WAIT_STATES=2) -> pready high in the 3rd access cycle of each transfer; read prdata=0xA5; prdata=0x00 in all other cycles.
- Read addr 0x20 (DEPTH=16) -> prdata=0x00; pslverr=1 with pready under the macro; registers unchanged.
- Back-to-back writes of 0x11 to addr 0 and 0x22 to addr 1 with no idle cycle, then reads -> 0x11 and 0x22; each transfer takes 4 cycles.
- psel dropped in the 1st access cycle of a write of 0x77 to addr 5 -> FSM returns to IDLE; reg[5] keeps its old value; pready never asserts.
- prst pulsed during WAIT after writing 0x3C to addr 2 -> outputs 0 immediately; a subsequent read of addr 2 returns 0x00.
- WAIT_STATES=0 write then read of addr 7 with 0x5A -> pready=1 in the first access cycle; total 2 cycles per transfer; read 0x5A.
